// File: rtl/note_game_pkg.sv
// note_game_pkg: shared definitions for the note game controller.
//   - game_state_t : two-bit game state encoding driven onto the state port
//   - PATTERN_ROM  : note pattern, one 3-bit lane mask per entry
//   - LANE_*       : bit positions of the lanes inside btn / lanes
package note_game_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_state_t;

    localparam int LANE_BLUE  = 0;
    localparam int LANE_GREEN = 1;
    localparam int LANE_RED   = 2;

    localparam int ROM_DEPTH = 8;

    // Entry 0 is the rightmost element: 000, 001, 010, 100, 001, 010, 100, 111.
    localparam logic [ROM_DEPTH-1:0][2:0] PATTERN_ROM = {
        3'b111, 3'b100, 3'b010, 3'b001,
        3'b100, 3'b010, 3'b001, 3'b000
    };

endpackage

// File: rtl/note_game_ctrl_edge.sv
// edge_detect: rising-edge detector with a registered history.
//   clk   : system clock
//   reset : asynchronous active-high reset, history cleared to 0
//   din   : input vector (synchronous to clk)
//   rise  : din & ~history, valid in the same cycle din is first high
module edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] din_q_r;

    // History register: last cycle's value of din.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q_r <= {WIDTH{1'b0}};
        end else begin
            din_q_r <= din;
        end
    end

    assign rise = din & ~din_q_r;

endmodule

// File: rtl/note_game_ctrl.sv
// note_game_ctrl: steps the note pattern, scrolls the active note, judges
// lane presses against the hit window, keeps scores and runs the turn FSM.
//   clk, reset  : clock and asynchronous active-high reset
//   start       : level; its rising edge starts a game / returns from QDONE
//   btn[2:0]    : lane buttons (red, green, blue)
//   move_tick   : one-cycle pulse, advances the note by one row
//   position    : current note row
//   lanes       : lanes of the current note, 0 outside game states
//   p1/p2_score : per-player scores
//   state       : game state
//   hit_pulse   : one cycle, note completed
//   miss_pulse  : one cycle, note missed or wrong press
module note_game_ctrl
    import note_game_pkg::*;
#(
    parameter logic [9:0] START_Y     = 10'd0,
    parameter logic [9:0] END_Y       = 10'd479,
    parameter logic [9:0] HIT_Y       = 10'd400,
    parameter logic [9:0] HIT_WIN     = 10'd10,
    parameter logic [3:0] WIN_SCORE   = 4'd10,
    parameter int         PATTERN_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] btn,
    input  logic       move_tick,
    output logic [9:0] position,
    output logic [2:0] lanes,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] state,
    output logic       hit_pulse,
    output logic       miss_pulse
);

    // Window bounds in 11 bits; the lower bound clamps at row 0.
    localparam logic [10:0] WIN_LO = (HIT_WIN > HIT_Y) ? 11'd0 :
                                     ({1'b0, HIT_Y} - {1'b0, HIT_WIN});
    localparam logic [10:0] WIN_HI = {1'b0, HIT_Y} + {1'b0, HIT_WIN};
    localparam logic [2:0]  LAST_IDX = 3'(PATTERN_LEN - 1);
    localparam logic [3:0]  TURN_LEN = 4'(PATTERN_LEN);

    game_state_t state_r, state_nxt;
    logic [9:0]  position_r, position_nxt;
    logic [2:0]  lanes_r, lanes_nxt;
    logic [2:0]  idx_r, idx_nxt;
    logic [3:0]  count_r, count_nxt;
    logic [2:0]  mask_r, mask_nxt;
    logic [3:0]  p1_r, p1_nxt, p2_r, p2_nxt;
    logic        hit_r, hit_nxt, miss_r, miss_nxt;

    logic [2:0]  btn_rise_s;
    logic [0:0]  start_rise_s;
    logic        in_win_s, complete_s, at_end_s, won_s;
    logic [2:0]  good_s, bad_s, new_mask_s;
    logic [3:0]  active_score_s, bumped_s, count_inc_s;

    edge_detect #(.WIDTH(3)) u_btn_edge (
        .clk(clk), .reset(reset), .din(btn), .rise(btn_rise_s)
    );

    edge_detect #(.WIDTH(1)) u_start_edge (
        .clk(clk), .reset(reset), .din(start), .rise(start_rise_s)
    );

    // Judgment of the current cycle, based on position before any increment.
    always_comb begin
        in_win_s       = ({1'b0, position_r} >= WIN_LO) && ({1'b0, position_r} <= WIN_HI);
        good_s         = btn_rise_s & lanes_r & {3{in_win_s}};
        bad_s          = btn_rise_s & ~good_s;
        new_mask_s     = mask_r | good_s;
        complete_s     = (lanes_r != 3'b000) && (new_mask_s == lanes_r);
        at_end_s       = move_tick && (position_r == END_Y);
        active_score_s = (state_r == QGAME_2) ? p2_r : p1_r;
        bumped_s       = (active_score_s >= WIN_SCORE) ? active_score_s : (active_score_s + 4'd1);
        won_s          = complete_s && (bumped_s == WIN_SCORE);
        count_inc_s    = count_r + 4'd1;
    end

    // Next-state and next-output logic of the game FSM.
    always_comb begin
        state_nxt    = state_r;
        position_nxt = position_r;
        idx_nxt      = idx_r;
        count_nxt    = count_r;
        mask_nxt     = mask_r;
        p1_nxt       = p1_r;
        p2_nxt       = p2_r;
        hit_nxt      = 1'b0;
        miss_nxt     = 1'b0;
        case (state_r)
            QI: begin
                position_nxt = START_Y;
                if (start_rise_s[0]) begin
                    state_nxt = QGAME_1;
                    idx_nxt   = 3'd0;
                    count_nxt = 4'd0;
                    mask_nxt  = 3'b000;
                end else begin
                    state_nxt = QI;
                end
            end
            QGAME_1, QGAME_2: begin
                // An empty note reaching END_Y is consumed without a miss.
                miss_nxt = (|bad_s) || (at_end_s && !complete_s && (lanes_r != 3'b000));
                if (complete_s || at_end_s) begin
                    position_nxt = START_Y;
                    mask_nxt     = 3'b000;
                    idx_nxt      = (idx_r == LAST_IDX) ? 3'd0 : (idx_r + 3'd1);
                    count_nxt    = (count_inc_s == TURN_LEN) ? 4'd0 : count_inc_s;
                    if (complete_s) begin
                        hit_nxt = 1'b1;
                        if (state_r == QGAME_1) begin
                            p1_nxt = bumped_s;
                        end else begin
                            p2_nxt = bumped_s;
                        end
                    end else begin
                        hit_nxt = 1'b0;
                    end
                    // Winning takes precedence over the turn swap.
                    if (won_s) begin
                        state_nxt = QDONE;
                    end else if (count_inc_s == TURN_LEN) begin
                        state_nxt = (state_r == QGAME_1) ? QGAME_2 : QGAME_1;
                    end else begin
                        state_nxt = state_r;
                    end
                end else begin
                    mask_nxt     = new_mask_s;
                    position_nxt = move_tick ? (position_r + 10'd1) : position_r;
                end
            end
            QDONE: begin
                if (start_rise_s[0]) begin
                    state_nxt    = QI;
                    p1_nxt       = 4'd0;
                    p2_nxt       = 4'd0;
                    position_nxt = START_Y;
                end else begin
                    state_nxt = QDONE;
                end
            end
            default: begin
                state_nxt = QI;
            end
        endcase
        lanes_nxt = ((state_nxt == QGAME_1) || (state_nxt == QGAME_2)) ? PATTERN_ROM[idx_nxt] : 3'b000;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= QI;
            position_r <= START_Y;
            lanes_r    <= 3'b000;
            idx_r      <= 3'd0;
            count_r    <= 4'd0;
            mask_r     <= 3'b000;
            p1_r       <= 4'd0;
            p2_r       <= 4'd0;
            hit_r      <= 1'b0;
            miss_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            position_r <= position_nxt;
            lanes_r    <= lanes_nxt;
            idx_r      <= idx_nxt;
            count_r    <= count_nxt;
            mask_r     <= mask_nxt;
            p1_r       <= p1_nxt;
            p2_r       <= p2_nxt;
            hit_r      <= hit_nxt;
            miss_r     <= miss_nxt;
        end
    end

    assign state      = state_r;
    assign position   = position_r;
    assign lanes      = lanes_r;
    assign p1_score   = p1_r;
    assign p2_score   = p2_r;
    assign hit_pulse  = hit_r;
    assign miss_pulse = miss_r;

endmodule

// File: tb/tb_note_game_ctrl.sv
// tb_note_game_ctrl: directed bench for note_game_ctrl. A second instance
// with the hit zone moved to row 470 covers a completing press at END_Y.
module tb_note_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, move_tick, start2, move_tick2;
    logic [2:0] btn, btn2;
    logic [9:0] position, position2;
    logic [2:0] lanes, lanes2;
    logic [3:0] p1_score, p2_score, p1_score2, p2_score2;
    logic [1:0] state, state2;
    logic       hit_pulse, miss_pulse, hit_pulse2, miss_pulse2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    note_game_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .move_tick(move_tick),
        .position(position), .lanes(lanes), .p1_score(p1_score), .p2_score(p2_score),
        .state(state), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    note_game_ctrl #(.HIT_Y(10'd470), .HIT_WIN(10'd10)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .btn(btn2), .move_tick(move_tick2),
        .position(position2), .lanes(lanes2), .p1_score(p1_score2), .p2_score(p2_score2),
        .state(state2), .hit_pulse(hit_pulse2), .miss_pulse(miss_pulse2)
    );

    typedef struct {
        int         pre;
        logic       st;
        logic [2:0] b;
        logic       t;
        logic [1:0] e_state;
        logic [9:0] e_pos;
        logic [2:0] e_lanes;
        logic       e_hit;
        logic       e_miss;
        logic [3:0] e_p1;
        logic [3:0] e_p2;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] es, input logic [9:0] ep,
                           input logic [2:0] el, input logic eh, input logic em,
                           input logic [3:0] e1, input logic [3:0] e2);
        chk({tag, ".state"}, int'(state), int'(es));
        chk({tag, ".position"}, int'(position), int'(ep));
        chk({tag, ".lanes"}, int'(lanes), int'(el));
        chk({tag, ".hit"}, int'(hit_pulse), int'(eh));
        chk({tag, ".miss"}, int'(miss_pulse), int'(em));
        chk({tag, ".p1"}, int'(p1_score), int'(e1));
        chk({tag, ".p2"}, int'(p2_score), int'(e2));
    endtask

    task automatic apply(input logic st, input logic [2:0] b, input logic t);
        start = st; btn = b; move_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic apply2(input logic st, input logic [2:0] b, input logic t);
        start2 = st; btn2 = b; move_tick2 = t;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 3'b000, 1'b1);
    endtask

    // Scroll the current note to row 400 and complete it with one press.
    task automatic hit_note(input logic [2:0] l);
        tick_n(400);
        apply(1'b0, l, 1'b0);
        chk($sformatf("hit_note_%03b", l), int'(hit_pulse), 1);
        apply(1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        int pulses;
        //            pre  st    btn     tick   state  pos      lanes   hit   miss  p1    p2
        tbl[0]  = '{0,   1'b1, 3'b000, 1'b0, 2'b01, 10'd0,   3'b000, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[1]  = '{0,   1'b0, 3'b000, 1'b1, 2'b01, 10'd1,   3'b000, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[2]  = '{478, 1'b0, 3'b000, 1'b1, 2'b01, 10'd0,   3'b001, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[3]  = '{400, 1'b0, 3'b001, 1'b0, 2'b01, 10'd0,   3'b010, 1'b1, 1'b0, 4'd1, 4'd0};
        tbl[4]  = '{0,   1'b0, 3'b000, 1'b0, 2'b01, 10'd0,   3'b010, 1'b0, 1'b0, 4'd1, 4'd0};
        tbl[5]  = '{200, 1'b0, 3'b010, 1'b0, 2'b01, 10'd200, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0};
        tbl[6]  = '{0,   1'b0, 3'b000, 1'b0, 2'b01, 10'd200, 3'b010, 1'b0, 1'b0, 4'd1, 4'd0};
        tbl[7]  = '{195, 1'b0, 3'b100, 1'b0, 2'b01, 10'd395, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0};
        tbl[8]  = '{10,  1'b0, 3'b010, 1'b0, 2'b01, 10'd0,   3'b100, 1'b1, 1'b0, 4'd2, 4'd0};
        tbl[9]  = '{479, 1'b0, 3'b000, 1'b1, 2'b01, 10'd0,   3'b001, 1'b0, 1'b1, 4'd2, 4'd0};
        tbl[10] = '{400, 1'b0, 3'b011, 1'b0, 2'b01, 10'd0,   3'b010, 1'b1, 1'b1, 4'd3, 4'd0};
        tbl[11] = '{400, 1'b0, 3'b010, 1'b0, 2'b01, 10'd0,   3'b100, 1'b1, 1'b0, 4'd4, 4'd0};
        tbl[12] = '{400, 1'b0, 3'b100, 1'b0, 2'b01, 10'd0,   3'b111, 1'b1, 1'b0, 4'd5, 4'd0};
        tbl[13] = '{392, 1'b0, 3'b101, 1'b0, 2'b01, 10'd392, 3'b111, 1'b0, 1'b0, 4'd5, 4'd0};
        tbl[14] = '{6,   1'b0, 3'b010, 1'b0, 2'b10, 10'd0,   3'b000, 1'b1, 1'b0, 4'd6, 4'd0};

        reset = 1'b1;
        start = 1'b0; btn = 3'b000; move_tick = 1'b0;
        start2 = 1'b0; btn2 = 3'b000; move_tick2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 2'b00, 10'd0, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
        reset = 1'b0;
        apply(1'b0, 3'b001, 1'b1);
        chk_all("idle_qi", 2'b00, 10'd0, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
        apply(1'b0, 3'b000, 1'b0);

        // Player 1 turn: empty note, single hits, misses, chord, turn swap.
        for (int v = 0; v < 15; v++) begin
            tick_n(tbl[v].pre);
            apply(tbl[v].st, tbl[v].b, tbl[v].t);
            chk_all($sformatf("vec%0d", v), tbl[v].e_state, tbl[v].e_pos, tbl[v].e_lanes,
                    tbl[v].e_hit, tbl[v].e_miss, tbl[v].e_p1, tbl[v].e_p2);
        end

        // Player 2 turn: empty note, then a held button producing one event.
        tick_n(479);
        apply(1'b0, 3'b000, 1'b1);
        chk_all("p2_empty", 2'b10, 10'd0, 3'b001, 1'b0, 1'b0, 4'd6, 4'd0);
        tick_n(400);
        apply(1'b0, 3'b001, 1'b0);
        chk_all("p2_hit", 2'b10, 10'd0, 3'b010, 1'b1, 1'b0, 4'd6, 4'd1);
        pulses = 0;
        for (int i = 0; i < 49; i++) begin
            apply(1'b0, 3'b001, 1'b0);
            pulses += int'(hit_pulse) + int'(miss_pulse);
        end
        chk("held_btn_pulses", pulses, 0);
        chk("held_btn_p2", int'(p2_score), 1);
        apply(1'b0, 3'b000, 1'b0);
        hit_note(3'b010); hit_note(3'b100); hit_note(3'b001);
        hit_note(3'b010); hit_note(3'b100); hit_note(3'b111);
        chk_all("swap_back", 2'b01, 10'd0, 3'b000, 1'b0, 1'b0, 4'd6, 4'd7);

        // Player 1 reaches the winning score.
        tick_n(480);
        hit_note(3'b001); hit_note(3'b010); hit_note(3'b100);
        tick_n(400);
        apply(1'b0, 3'b001, 1'b0);
        chk_all("win", 2'b11, 10'd0, 3'b000, 1'b1, 1'b0, 4'd10, 4'd7);
        apply(1'b0, 3'b000, 1'b1);
        chk_all("frozen1", 2'b11, 10'd0, 3'b000, 1'b0, 1'b0, 4'd10, 4'd7);
        apply(1'b0, 3'b100, 1'b1);
        chk_all("frozen2", 2'b11, 10'd0, 3'b000, 1'b0, 1'b0, 4'd10, 4'd7);
        apply(1'b1, 3'b000, 1'b0);
        chk_all("done_to_qi", 2'b00, 10'd0, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
        apply(1'b0, 3'b000, 1'b0);

        // Asynchronous reset in the middle of a note.
        apply(1'b1, 3'b000, 1'b0);
        apply(1'b0, 3'b000, 1'b0);
        tick_n(480);
        hit_note(3'b001);
        tick_n(50);
        chk_all("pre_reset", 2'b01, 10'd50, 3'b010, 1'b0, 1'b0, 4'd1, 4'd0);
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 2'b00, 10'd0, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Completing press coinciding with move_tick at END_Y (zone 460..480).
        apply2(1'b1, 3'b000, 1'b0);
        chk("end_state", int'(state2), 1);
        for (int i = 0; i < 480; i++) apply2(1'b0, 3'b000, 1'b1);
        chk("end_lanes", int'(lanes2), 1);
        for (int i = 0; i < 479; i++) apply2(1'b0, 3'b000, 1'b1);
        chk("end_pos", int'(position2), 479);
        apply2(1'b0, 3'b001, 1'b1);
        chk("end_hit", int'(hit_pulse2), 1);
        chk("end_nomiss", int'(miss_pulse2), 0);
        chk("end_p1", int'(p1_score2), 1);
        chk("end_pos0", int'(position2), 0);
        chk("end_lanes2", int'(lanes2), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
